// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
//
// Bundles every handshake and bus signal around the ALU issue controller:
//   request side : req_valid/req_ready, req_dat1, req_dat2, req_op, req_rd
//   ALU side     : dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU (toward ALU)
//                  ALU_ready, ALU_out, ALU_overflow, ALU_con_met, ALU_zero (from ALU)
//   result side  : res_valid/res_ready, res_data, res_rd, res_flags,
//                  res_branch, res_err
//
// Modports:
//   slave  - the issue controller itself
//   master - the surrounding environment (IDU/CU, ALU and result consumer)
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;

    // Request from IDU/CU
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dat1;
    logic [31:0] req_dat2;
    logic [4:0]  req_op;
    logic [4:0]  req_rd;

    // Toward the ALU
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  Instruction_to_ALU;

    // From the ALU
    logic        ALU_ready;
    logic        ALU_overflow;
    logic        ALU_con_met;
    logic        ALU_zero;
    logic [31:0] ALU_out;

    // Result toward the consumer
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic [2:0]  res_flags;
    logic        res_branch;
    logic        res_err;

    modport slave (
        input  req_valid, req_dat1, req_dat2, req_op, req_rd,
        output req_ready,
        output dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU,
        input  ALU_ready, ALU_overflow, ALU_con_met, ALU_zero, ALU_out,
        output res_valid, res_data, res_rd, res_flags, res_branch, res_err,
        input  res_ready
    );

    modport master (
        output req_valid, req_dat1, req_dat2, req_op, req_rd,
        input  req_ready,
        input  dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU,
        output ALU_ready, ALU_overflow, ALU_con_met, ALU_zero, ALU_out,
        input  res_valid, res_data, res_rd, res_flags, res_branch, res_err,
        output res_ready
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issues one operation at a time from the IDU/CU to an ALU and returns the
// captured result with a valid/ready handshake.
//
// Flow: IDLE --accept--> BUSY (dat_ready high, waits for ALU_ready or timeout)
//       --> GAP (one cycle, dat_ready low) --> DONE (res_valid until res_ready)
//       --> IDLE.  Invalid opcodes (16-31) skip straight from IDLE to DONE
//       with res_err set and never touch the ALU.
//
// Ports:
//   soc_clk  - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   bus      - alu_issue_ctrl_if.slave: request, ALU and result signals
//
// Parameter:
//   TIMEOUT_CYCLES - maximum cycles spent in BUSY waiting for ALU_ready (>=1)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             soc_clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Opcode classification: 0-5 branch, 6-15 I/R, 16-31 invalid.
    function automatic logic is_invalid_op(input logic [4:0] op);
        return op[4];
    endfunction

    function automatic logic is_branch_op(input logic [4:0] op);
        return (op <= 5'd5);
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_p0;

    // Control strobes from the next-state logic
    logic             accept;
    logic             cap_ok;
    logic             cap_tmo;
    logic             req_ready_c;
    logic             dat_ready_c;
    logic             res_valid_c;

    // Operand stage: latched on accept, held stable toward the ALU
    logic [31:0]      dat1_p0;
    logic [31:0]      dat2_p0;
    logic [4:0]       op_p0;
    logic [4:0]       rd_p0;

    // Result stage: captured at the end of BUSY (or on an invalid accept)
    logic [31:0]      res_data_p1;
    logic [2:0]       res_flags_p1;
    logic             res_branch_p1;
    logic             res_err_p1;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        dat_ready_c = 1'b0;
        res_valid_c = 1'b0;
        accept      = 1'b0;
        cap_ok      = 1'b0;
        cap_tmo     = 1'b0;

        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = is_invalid_op(bus.req_op) ? DONE : BUSY;
                end
            end

            BUSY: begin
                dat_ready_c = 1'b1;
                // ALU_ready takes priority over the final timeout cycle.
                if (bus.ALU_ready) begin
                    cap_ok    = 1'b1;
                    state_nxt = GAP;
                end else if (cnt_p0 == CNT_LAST) begin
                    cap_tmo   = 1'b1;
                    state_nxt = GAP;
                end
            end

            // One dead cycle so the ALU always sees dat_ready low between
            // back-to-back operations.
            GAP: begin
                state_nxt = DONE;
            end

            DONE: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // BUSY cycle counter: 0 on entry, +1 each cycle spent in BUSY
    // ---------------------------------------------------------------------
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if ((state == BUSY) && (state_nxt == BUSY)) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end else begin
            cnt_p0 <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Operand stage
    // ---------------------------------------------------------------------
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            dat1_p0 <= '0;
            dat2_p0 <= '0;
            op_p0   <= '0;
            rd_p0   <= '0;
        end else if (accept) begin
            dat1_p0 <= bus.req_dat1;
            dat2_p0 <= bus.req_dat2;
            op_p0   <= bus.req_op;
            rd_p0   <= bus.req_rd;
        end
    end

    // ---------------------------------------------------------------------
    // Result stage
    // ---------------------------------------------------------------------
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            res_data_p1   <= '0;
            res_flags_p1  <= '0;
            res_branch_p1 <= 1'b0;
            res_err_p1    <= 1'b0;
        end else begin
            // Invalid opcode: error result is ready right away, ALU untouched.
            if (accept && is_invalid_op(bus.req_op)) begin
                res_data_p1   <= '0;
                res_flags_p1  <= '0;
                res_branch_p1 <= 1'b0;
                res_err_p1    <= 1'b1;
            end

            if (cap_ok) begin
                res_data_p1   <= bus.ALU_out;
                res_flags_p1  <= {bus.ALU_overflow, bus.ALU_con_met, bus.ALU_zero};
                res_branch_p1 <= is_branch_op(op_p0);
                res_err_p1    <= 1'b0;
            end

            // Timeout: report an error with a cleared payload.
            if (cap_tmo) begin
                res_data_p1   <= '0;
                res_flags_p1  <= '0;
                res_branch_p1 <= 1'b0;
                res_err_p1    <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output mapping
    // ---------------------------------------------------------------------
    assign bus.req_ready          = req_ready_c;
    assign bus.dat_ready          = dat_ready_c;
    assign bus.res_valid          = res_valid_c;

    assign bus.ALU_dat1           = dat1_p0;
    assign bus.ALU_dat2           = dat2_p0;
    assign bus.Instruction_to_ALU = op_p0;

    assign bus.res_data           = res_data_p1;
    assign bus.res_rd             = rd_p0;
    assign bus.res_flags          = res_flags_p1;
    assign bus.res_branch         = res_branch_p1;
    assign bus.res_err            = res_err_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Scoreboard bench for alu_issue_ctrl. The bench plays the IDU/CU, the ALU
// (with a small behavioural ALU model) and the result consumer. Expected
// results are pushed when a request is driven and popped when res_valid
// appears.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int TIMEOUT = 8;

    logic soc_clk;
    logic reset;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .soc_clk (soc_clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [2:0]  flags;
        logic        branch;
        logic        chk_branch;
        logic        err;
        int          lat;
        int          dr_cycles;
        int          done_cycles;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    initial begin
        soc_clk = 1'b0;
        forever #5 soc_clk = ~soc_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // Reference ALU: returns {overflow, con_met, zero, result}.
    function automatic logic [34:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0]        r;
        logic               ov;
        logic               cm;
        logic               z;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        r  = '0;
        ov = 1'b0;
        cm = 1'b0;
        case (op)
            5'd0:  cm = (a == b);
            5'd1:  cm = (a != b);
            5'd2:  cm = (sa < sb);
            5'd3:  cm = (sa >= sb);
            5'd4:  cm = (a < b);
            5'd5:  cm = (a >= b);
            5'd6:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd7:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd8:  r = a & b;
            5'd9:  r = a | b;
            5'd10: r = a ^ b;
            5'd11: r = a << b[4:0];
            5'd12: r = a >> b[4:0];
            5'd13: r = sa >>> b[4:0];
            5'd14: r = {31'b0, sa < sb};
            default: r = {31'b0, a < b};
        endcase
        z = (op > 5'd5) && (r == 32'd0);
        return {ov, cm, z, r};
    endfunction

    task automatic drive_alu(input logic rdy, input logic [34:0] m);
        bus.ALU_ready    = rdy;
        bus.ALU_out      = m[31:0];
        bus.ALU_zero     = m[32];
        bus.ALU_con_met  = m[33];
        bus.ALU_overflow = m[34];
    endtask

    function automatic logic [34:0] junk();
        return {3'b111, 32'($urandom())};
    endfunction

    // Issue one operation and follow it until the controller returns to IDLE.
    // k : ALU_ready is sampled k edges after dat_ready rises (1..TIMEOUT);
    //     any other value means the ALU never answers.
    // bp: number of DONE cycles with res_ready held low.
    task automatic run_op(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input int k, input int bp);
        exp_t        ex;
        exp_t        got;
        logic [34:0] m;
        logic        answers;
        int          last_busy;
        int          dr_cnt;
        int          done_cnt;
        int          first_i;
        bit          seen;
        bit          exited;
        bit          ops_ok;
        bit          stable_ok;
        logic [31:0] s_data;
        logic [4:0]  s_rd;
        logic [2:0]  s_flags;
        logic        s_br;
        logic        s_err;

        m       = alu_model(op, d1, d2);
        answers = (op < 5'd16) && (k >= 1) && (k <= TIMEOUT);

        ex.rd          = rd;
        ex.done_cycles = bp + 1;
        if (op >= 5'd16) begin
            ex.data = '0; ex.flags = '0; ex.branch = 1'b0; ex.chk_branch = 1'b1;
            ex.err = 1'b1; ex.lat = 1; ex.dr_cycles = 0; last_busy = -1;
        end else if (answers) begin
            ex.data = m[31:0]; ex.flags = m[34:32]; ex.branch = (op <= 5'd5);
            ex.chk_branch = 1'b1; ex.err = 1'b0; ex.lat = k + 2; ex.dr_cycles = k;
            last_busy = k - 1;
        end else begin
            ex.data = '0; ex.flags = '0; ex.branch = 1'b0; ex.chk_branch = 1'b0;
            ex.err = 1'b1; ex.lat = TIMEOUT + 2; ex.dr_cycles = TIMEOUT;
            last_busy = TIMEOUT - 1;
        end
        exp_q.push_back(ex);

        check_val("idle_req_ready", 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_dat1  = d1;
        bus.req_dat2  = d2;
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.res_ready = (bp == 0);
        drive_alu(1'b1, junk());
        @(posedge soc_clk); #1;

        // Scramble the request bus so only latched values can reach the ALU.
        bus.req_valid = 1'b0;
        bus.req_dat1  = $urandom();
        bus.req_dat2  = $urandom();
        bus.req_op    = 5'($urandom());
        bus.req_rd    = 5'($urandom());

        seen = 0; exited = 0; ops_ok = 1; stable_ok = 1;
        dr_cnt = 0; done_cnt = 0; first_i = -1;
        s_data = '0; s_rd = '0; s_flags = '0; s_br = 1'b0; s_err = 1'b0;

        for (int i = 0; i < 64 && !exited; i++) begin
            if (bus.dat_ready) begin
                dr_cnt++;
                if (bus.ALU_dat1 !== d1 || bus.ALU_dat2 !== d2 || bus.Instruction_to_ALU !== op)
                    ops_ok = 0;
            end
            if (bus.res_valid) begin
                if (!seen) begin
                    seen    = 1;
                    first_i = i;
                    got     = exp_q.pop_front();
                    check_val("res_data", bus.res_data, got.data);
                    check_val("res_rd", 32'(bus.res_rd), 32'(got.rd));
                    check_val("res_flags", 32'(bus.res_flags), 32'(got.flags));
                    check_val("res_err", 32'(bus.res_err), 32'(got.err));
                    if (got.chk_branch)
                        check_val("res_branch", 32'(bus.res_branch), 32'(got.branch));
                    s_data = bus.res_data; s_rd = bus.res_rd; s_flags = bus.res_flags;
                    s_br = bus.res_branch; s_err = bus.res_err;
                end else if (bus.res_data !== s_data || bus.res_rd !== s_rd ||
                             bus.res_flags !== s_flags || bus.res_branch !== s_br ||
                             bus.res_err !== s_err) begin
                    stable_ok = 0;
                end
                if (bus.req_ready !== 1'b0) stable_ok = 0;
                bus.res_ready = (done_cnt >= bp);
                done_cnt++;
            end else if (seen) begin
                exited = 1;
            end

            if (!exited) begin
                if (answers && i == k - 1) drive_alu(1'b1, m);
                else if (i <= last_busy)   drive_alu(1'b0, junk());
                else                       drive_alu(1'b1, junk());
                @(posedge soc_clk); #1;
            end
        end

        if (!seen) begin
            check_val("res_valid_seen", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            check_val("latency", first_i + 1, got.lat);
            check_val("dat_ready_cycles", dr_cnt, got.dr_cycles);
            check_val("done_cycles", done_cnt, got.done_cycles);
            check_val("alu_operands", 32'(ops_ok), 32'd1);
            check_val("res_stable", 32'(stable_ok), 32'd1);
            check_val("back_to_idle", 32'(exited), 32'd1);
        end
    endtask

    initial begin
        bit no_valid;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_dat1  = '0;
        bus.req_dat2  = '0;
        bus.req_op    = '0;
        bus.req_rd    = '0;
        bus.res_ready = 1'b0;
        drive_alu(1'b0, '0);

        repeat (3) @(posedge soc_clk);
        #1;
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_dat_ready", 32'(bus.dat_ready), 32'd0);
        check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("rst_res_data", bus.res_data, 32'd0);
        check_val("rst_res_flags", 32'(bus.res_flags), 32'd0);
        check_val("rst_res_err", 32'(bus.res_err), 32'd0);
        check_val("rst_alu_dat1", bus.ALU_dat1, 32'd0);
        check_val("rst_instr", 32'(bus.Instruction_to_ALU), 32'd0);
        reset = 1'b0;

        // ADD, BEQ, invalid, timeout, late answer, back-pressure, boundaries
        run_op(5'd6,  32'd5,          32'd7,          5'd3,  2, 0);
        run_op(5'd0,  32'hA5,         32'hA5,         5'd1,  1, 0);
        run_op(5'd20, 32'h1234_5678,  32'h9ABC_DEF0,  5'd9,  3, 0);
        run_op(5'd7,  32'd100,        32'd1,          5'd5,  0, 0);
        run_op(5'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd6,  TIMEOUT, 0);
        run_op(5'd9,  32'h0000_00F0,  32'h0000_0F00,  5'd12, 3, 5);
        run_op(5'd15, 32'd3,          32'd9,          5'd31, 1, 0);
        run_op(5'd16, 32'hDEAD_BEEF,  32'h1,          5'd7,  1, 2);
        run_op(5'd5,  32'd10,         32'd4,          5'd2,  4, 1);
        run_op(5'd6,  32'h7FFF_FFFF,  32'd1,          5'd8,  1, 0);

        // Reset one cycle after dat_ready rises: operation is dropped.
        check_val("rb_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = 5'd6;
        bus.req_dat1  = 32'd1;
        bus.req_dat2  = 32'd2;
        bus.req_rd    = 5'd4;
        drive_alu(1'b0, '0);
        @(posedge soc_clk); #1;
        bus.req_valid = 1'b0;
        check_val("rb_dat_ready_up", 32'(bus.dat_ready), 32'd1);
        @(posedge soc_clk); #1;
        reset = 1'b1;
        #1;
        check_val("rb_dat_ready", 32'(bus.dat_ready), 32'd0);
        check_val("rb_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rb_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("rb_alu_dat2", bus.ALU_dat2, 32'd0);
        no_valid = 1;
        drive_alu(1'b1, junk());
        repeat (2) begin
            @(posedge soc_clk); #1;
            if (bus.res_valid !== 1'b0 || bus.dat_ready !== 1'b0) no_valid = 0;
        end
        check_val("rb_quiet", 32'(no_valid), 32'd1);
        reset = 1'b0;
        // First accept lands on the first edge after deassertion.
        run_op(5'd10, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd11, 2, 0);

        for (int n = 0; n < 8; n++) begin
            run_op(5'($urandom_range(0, 19)), $urandom(), $urandom(),
                   5'($urandom_range(0, 31)), int'($urandom_range(0, TIMEOUT + 1)),
                   int'($urandom_range(0, 3)));
        end

        check_val("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8: maximum number of cycles spent in BUSY waiting for ALU_ready.
REQ-002 soc_clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  IDU/CU has an operation to issue.
REQ-005 req_ready  out  1  block can accept an operation.
REQ-006 req_dat1, req_dat2  in  32 each  source operands.
REQ-007 req_op  in  5  ALU operation code: 0-5 branch, 6-15 I/R, 16-31 invalid.
REQ-008 req_rd  in  5  destination register tag, passed through to the result.
REQ-009 dat_ready  out  1  operation valid toward ALU; held high until ALU_ready or timeout.
REQ-010 ALU_dat1, ALU_dat2  out  32 each  registered operands to ALU.
REQ-011 Instruction_to_ALU  out  5  registered operation code to ALU.
REQ-012 ALU_ready, ALU_overflow, ALU_con_met, ALU_zero  in  1 each  ALU completion and flags.
REQ-013 ALU_out  in  32  ALU result.
REQ-014 res_valid  out  1  result available; res_ready  in  1  consumer accepts the result.
REQ-015 res_data  out  32  captured result; res_rd  out  5  destination tag.
REQ-016 res_flags  out  3  {overflow, con_met, zero}; res_branch  out  1  op was 0-5; res_err  out  1  invalid op or timeout.

Function
REQ-017 FSM SHALL have exactly four states: IDLE, BUSY, GAP, DONE.
REQ-018 IDLE: req_ready=1, dat_ready=0, res_valid=0; all other states: req_ready=0.
REQ-019 Accept occurs on a rising edge with req_valid&req_ready: req_dat1, req_dat2, req_op and req_rd SHALL be latched.
REQ-020 Accept with req_op<=15: go to BUSY; dat_ready=1 from the next cycle, and ALU_dat1, ALU_dat2 and Instruction_to_ALU hold the latched values, stable throughout BUSY.
REQ-021 Accept with req_op>=16: go directly to DONE with res_err=1, res_data=0, res_flags=0, res_branch=0; dat_ready is never asserted.
REQ-022 BUSY: a cycle counter starts at 0 on entry and increments each cycle.
REQ-023 BUSY, edge with ALU_ready=1: capture ALU_out, res_flags={ALU_overflow, ALU_con_met, ALU_zero} and res_err=0; set res_branch=(op<=5); go to GAP; dat_ready=0 next cycle.
REQ-024 BUSY, counter reaches TIMEOUT_CYCLES-1 with ALU_ready=0: go to GAP with res_err=1, res_data=0, res_flags=0.
REQ-025 ALU_ready together with the final timeout cycle: ALU_ready wins, res_err=0.
REQ-026 GAP: lasts one cycle with dat_ready=0, guaranteeing the ALU sees dat_ready low between operations; then go to DONE.
REQ-027 DONE: res_valid=1 and res_* held stable until an edge with res_ready=1, then go to IDLE.
REQ-028 res_ready already high on DONE entry: DONE lasts exactly one cycle.
REQ-029 ALU_ready while not in BUSY SHALL be ignored.
REQ-030 Latency, accept to res_valid for an ALU answering k cycles after dat_ready rises (k>=1): k+2 cycles; invalid op: 1 cycle.
REQ-031 No bypass: a new request is accepted only in IDLE, so throughput is at most one operation per latency+1 cycles.

Reset
REQ-032 reset asserted: immediately go to IDLE; req_ready=1; dat_ready, res_valid, res_err, res_branch=0; res_flags=0; all data/tag/opcode registers=0; counter=0.
REQ-033 reset during BUSY/GAP/DONE SHALL abort the operation without emitting res_valid; first accept allowed on the first edge after deassertion.

Verification
REQ-034 ADD: req_op=6, dat1=5, dat2=7, rd=3; ALU returns 12 with ALU_ready 2 cycles after dat_ready -> res_data=12, res_rd=3, res_flags=000, res_branch=0, res_err=0, res_valid 4 cycles after accept.
REQ-035 BEQ: req_op=0, dat1=dat2=0xA5; ALU_con_met=1 -> res_branch=1, res_flags=010, dat_ready low in GAP and DONE.
REQ-036 Invalid op: req_op=20 -> res_valid next cycle, res_err=1, dat_ready stays 0 throughout.
REQ-037 Timeout: ALU_ready held 0 -> dat_ready high exactly 8 cycles, res_err=1, res_data=0; ALU_ready at counter=7 -> res_err=0.
REQ-038 Back-pressure: res_ready=0 for 5 cycles in DONE -> res_* stable, req_ready=0; res_ready=1 -> IDLE next cycle, next request accepted.
REQ-039 Reset mid-BUSY: assert reset 1 cycle after dat_ready rises -> dat_ready=0 immediately, no res_valid, req_ready=1.
